// File: rtl/multi_mode_ff_bank.sv
// Multi-bit flip-flop bank emulating D, T, JK or SR behaviour per cycle, with
// clock enable, sticky illegal-SR detection and a saturating change counter.
module multi_mode_ff_bank #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter int               CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             err_clr,
    input  logic             cnt_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             chg,
    output logic             sr_err,
    output logic [WIDTH-1:0] err_bits,
    output logic [CNT_W-1:0] upd_cnt
);

    localparam logic [1:0]       MODE_D  = 2'b00;
    localparam logic [1:0]       MODE_T  = 2'b01;
    localparam logic [1:0]       MODE_JK = 2'b10;
    localparam logic [1:0]       MODE_SR = 2'b11;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // JK: set where J&~K, keep where ~K, so Q+ = J&~Q | ~K&Q.
    function automatic logic [WIDTH-1:0] jk_next(input logic [WIDTH-1:0] j,
                                                 input logic [WIDTH-1:0] k,
                                                 input logic [WIDTH-1:0] cur);
        return (j & ~cur) | (~k & cur);
    endfunction

    // SR: set on 10, clear on 01, hold on 00 and on the illegal 11.
    function automatic logic [WIDTH-1:0] sr_next(input logic [WIDTH-1:0] s,
                                                 input logic [WIDTH-1:0] r,
                                                 input logic [WIDTH-1:0] cur);
        return (s & ~r) | (cur & ~(s ^ r));
    endfunction

    logic [WIDTH-1:0] q_r;
    logic             chg_r;
    logic             sr_err_r;
    logic [WIDTH-1:0] err_bits_r;
    logic [CNT_W-1:0] upd_cnt_r;

    logic [WIDTH-1:0] q_next_s;
    logic [WIDTH-1:0] err_new_s;
    logic [WIDTH-1:0] err_next_s;
    logic [CNT_W-1:0] cnt_next_s;
    logic             changed_s;

    // Next-state selection for the register bits and the illegal-SR mask.
    always_comb begin
        q_next_s  = q_r;
        err_new_s = {WIDTH{1'b0}};
        if (en) begin
            case (mode)
                MODE_D:  q_next_s = a;
                MODE_T:  q_next_s = q_r ^ a;
                MODE_JK: q_next_s = jk_next(a, b, q_r);
                MODE_SR: begin
                    q_next_s  = sr_next(a, b, q_r);
                    err_new_s = a & b;
                end
                default: q_next_s = q_r;
            endcase
        end else begin
            q_next_s = q_r;
        end
    end

    // Error accumulation and saturating counter; clears win over updates.
    always_comb begin
        changed_s  = (q_next_s != q_r);
        err_next_s = err_bits_r | err_new_s;
        cnt_next_s = upd_cnt_r;
        if (err_clr) begin
            err_next_s = err_new_s;
        end else begin
            err_next_s = err_bits_r | err_new_s;
        end
        if (cnt_clr) begin
            cnt_next_s = {CNT_W{1'b0}};
        end else if (changed_s && (upd_cnt_r != CNT_MAX)) begin
            cnt_next_s = upd_cnt_r + CNT_ONE;
        end else begin
            cnt_next_s = upd_cnt_r;
        end
    end

    // State registers; asynchronous reset drops any pending update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r        <= RESET_VAL;
            chg_r      <= 1'b0;
            sr_err_r   <= 1'b0;
            err_bits_r <= {WIDTH{1'b0}};
            upd_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            q_r        <= q_next_s;
            chg_r      <= changed_s;
            sr_err_r   <= |err_next_s;
            err_bits_r <= err_next_s;
            upd_cnt_r  <= cnt_next_s;
        end
    end

    assign q        = q_r;
    assign qb       = ~q_r;
    assign chg      = chg_r;
    assign sr_err   = sr_err_r;
    assign err_bits = err_bits_r;
    assign upd_cnt  = upd_cnt_r;

endmodule

// File: doc/multi_mode_ff_bank.md
# multi_mode_ff_bank

Parametrised bank of WIDTH flip-flops that emulates D, T, JK or SR behaviour, selected per cycle by a mode input. It extends the single-bit JK/SR primitives to a multi-bit register. It adds a clock enable, a sticky detector for illegal SR inputs and a saturating count of register updates. It sits as the general-purpose storage element used by counters and control registers across the design.

## Interface
- WIDTH, 8, number of flip-flop bits in the bank (≥1)
- RESET_VAL, {WIDTH{1'b0}}, value loaded into q on reset
- CNT_W, 8, width of the update counter (≥2)

- clk  in  1  rising-edge clock; the only clock
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  clock enable; 0 = hold all state except the clear inputs
- mode  in  2  00 D, 01 T, 10 JK, 11 SR; sampled every enabled edge
- a  in  WIDTH  per-bit D / T / J / S input, depending on mode
- b  in  WIDTH  per-bit K / R input; ignored in D and T modes
- err_clr  in  1  synchronous clear of sr_err and err_bits
- cnt_clr  in  1  synchronous clear of upd_cnt
- q  out  WIDTH  registered state
- qb  out  WIDTH  always exactly ~q
- chg  out  1  high for the cycle after any q bit changed
- sr_err  out  1  sticky flag: an illegal SR combination was seen
- err_bits  out  WIDTH  sticky per-bit record of illegal SR bits
- upd_cnt  out  CNT_W  saturating count of edges on which q changed

## Operation
- Per-bit next state on a rising edge with en=1:
  - D: q ← a.
  - T: q ← q ^ a.
  - JK: 00 hold, 01 reset, 10 set, 11 toggle.
  - SR: 00 hold, 01 (S=0,R=1) reset, 10 set, 11 illegal → bit holds.
- All WIDTH bits update in parallel, with no inter-bit dependency.
- qb is driven as ~q. It never equals q, including during reset and SR-illegal cycles.
- Illegal SR: on an enabled edge with mode=11, every bit with a=b=1 sets its err_bits bit, and sr_err is set.
  - err_bits accumulates by OR.
  - sr_err = |err_bits.
- err_clr=1 zeroes err_bits and sr_err on that edge.
  - If a new illegal SR occurs on the same edge, the new bits win: the register result is the new illegal mask only.
- chg: registered; set to 1 on an edge where next q ≠ current q, otherwise 0.
- upd_cnt: increments by 1 on every edge where q changes. It holds at 2^CNT_W−1 (saturates, no wrap).
  - cnt_clr=1 zeroes it on that edge. Clear has priority over an increment on the same edge.
- en=0:
  - q holds and chg goes to 0.
  - No error detection; upd_cnt does not increment.
  - err_clr and cnt_clr still act.
- Mode change between cycles takes effect on the next enabled edge; there is no pipeline to flush.
- Reset (rst_n=0, asynchronous, immediate regardless of clk):
  - q=RESET_VAL, qb=~RESET_VAL.
  - chg=0, sr_err=0, err_bits=0, upd_cnt=0.
  - Reset mid-operation discards any pending update.
  - The first edge after rst_n rises behaves as a normal edge.

## Timing
- Latency: one cycle. Inputs sampled on edge N appear on q, qb, chg, err_bits, sr_err and upd_cnt immediately after edge N.
- All outputs are registers, with no combinational path from input to output. The exception is qb, which is a pure inverter of the q register.
- No handshake; the block accepts a new command on every enabled cycle.
- rst_n assertion is asynchronous. Deassertion is expected to be synchronised externally to clk.

## Test plan
- Reset and D mode:
  - Assert rst_n=0 mid-cycle → q=00, qb=FF, all flags 0 immediately.
  - Release, then mode=00, a=A5 → q=A5, chg=1, upd_cnt=1.
- T and JK modes, from q=A5:
  - mode=01, a=0F → q=AA.
  - mode=10, a=F0, b=0F → q=F0.
  - Repeat with a=FF, b=FF → q=0F (toggle), chg=1 each edge.
- SR illegal, from q=3C:
  - mode=11, a=81, b=01 → q=BC, err_bits=01, sr_err=1.
  - Next edge with a=00, b=00 and err_clr=1 together with a=02, b=02 → err_bits=02, sr_err=1, q=BC.
- Enable gating: en=0 with mode=00, a=FF for 3 cycles → q unchanged, chg=0, upd_cnt unchanged. cnt_clr=1 during en=0 → upd_cnt=0.
- Saturation, CNT_W=2: toggle q for 5 edges (T mode, a=01) → upd_cnt reads 1,2,3,3,3. cnt_clr on the same edge as a change → upd_cnt=0.
- No change: D mode with a equal to current q → chg=0, upd_cnt unchanged. Reset asserted during a toggle burst → q=RESET_VAL with no extra count.
